// File: rtl/uart_tx_frame_fsm.sv
// UART transmit framing controller: start bit, LSB-first data from the serializer,
// optional parity bit and one stop bit, driven onto a registered TX line.
module uart_tx_frame_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_P_DATA,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_latche_en,
  output logic                  o_ser_en,
  input  logic                  i_ser_data,
  input  logic                  i_ser_done,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   accept;
  logic   mux_bit;
  logic   par_en_q;
  logic   par_typ_q;
  logic   data_xor_q;
  logic   stop_bit_q;

  // A byte is taken in IDLE or in the STOP cycle; reset wins over a same-cycle accept.
  assign o_data_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept       = i_data_valid && o_data_ready && !i_reset;
  assign o_latche_en  = accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = DATA;
      DATA:    if (i_ser_done) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mux_bit  = 1'b1;
    o_ser_en = 1'b0;
    case (state_q)
      START:   mux_bit = 1'b0;
      DATA: begin
        mux_bit  = i_ser_data;
        o_ser_en = 1'b1;
      end
      PARITY:  mux_bit = data_xor_q ^ par_typ_q;
      default: mux_bit = 1'b1;
    endcase
  end

  // Line register plus the frame options captured at accept time.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_out   <= 1'b1;
      stop_bit_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      data_xor_q <= 1'b0;
    end else begin
      o_tx_out   <= mux_bit;
      stop_bit_q <= (state_q == STOP);
      if (accept) begin
        par_en_q   <= i_par_en;
        par_typ_q  <= i_par_typ;
        data_xor_q <= ^i_P_DATA;
      end
    end
  end

  // Busy stays up while the final stop bit is still on the line.
  assign o_busy = (state_q != IDLE) || stop_bit_q;

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// Self-checking bench for uart_tx_frame_fsm: directed frame table, multi-cycle
// corner sequences and randomized traffic against a frame-level reference model.
module tb_uart_tx_frame_fsm;
  localparam int W = 8;
  localparam int N = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data;
  logic         valid;
  logic         par_en;
  logic         par_typ;
  logic         ready;
  logic         latche;
  logic         ser_en;
  logic         ser_data;
  logic         ser_done;
  logic         tx;
  logic         busy;

  uart_tx_frame_fsm #(.DATA_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_P_DATA     (data),
    .i_data_valid (valid),
    .o_data_ready (ready),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_latche_en  (latche),
    .o_ser_en     (ser_en),
    .i_ser_data   (ser_data),
    .i_ser_done   (ser_done),
    .o_tx_out     (tx),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural serializer peer: load on strobe, shift LSB-first while enabled.
  logic [W-1:0] sh  = '0;
  int           cnt = 0;
  always @(posedge clk) begin
    if (latche) begin
      sh  <= data;
      cnt <= 0;
    end else if (ser_en) begin
      sh  <= sh >> 1;
      cnt <= cnt + 1;
    end
  end
  assign ser_data = sh[0];
  assign ser_done = ser_en && (cnt == W - 1);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: expected line/busy/ser_en per absolute cycle.
  logic exp_line [N];
  logic exp_busy [N];
  logic exp_ser  [N];
  logic act_line [N];
  logic act_busy [N];
  int   phase    = -1;
  int   len_cur  = 0;
  int   last_acc = -1;
  int   latche_seen = 0;
  int   ser_seen    = 0;
  int   last_latche = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic exp_ready;
    logic acc;
    int   len;
    logic b;
    @(negedge clk);
    exp_ready = (phase < 0) || (phase == len_cur - 1);
    acc       = !rst && valid && exp_ready;
    act_line[cyc] = tx;
    act_busy[cyc] = busy;
    check("tx_out",     {31'd0, tx},     {31'd0, exp_line[cyc]});
    check("busy",       {31'd0, busy},   {31'd0, exp_busy[cyc]});
    check("data_ready", {31'd0, ready},  {31'd0, exp_ready});
    check("latche_en",  {31'd0, latche}, {31'd0, acc});
    check("ser_en",     {31'd0, ser_en}, {31'd0, exp_ser[cyc]});
    if (latche === 1'b1) begin
      latche_seen++;
      last_latche = cyc;
    end
    if (ser_en === 1'b1) ser_seen++;
    if (rst) begin
      phase = -1;
      for (int k = cyc + 1; k < N; k++) begin
        exp_line[k] = 1'b1;
        exp_busy[k] = 1'b0;
        exp_ser[k]  = 1'b0;
      end
    end else if (acc) begin
      len = W + 2 + (par_en ? 1 : 0);
      for (int i = 0; i < len; i++) begin
        if (i == 0)                 b = 1'b0;
        else if (i <= W)            b = data[i-1];
        else if (par_en && i == W + 1)
          b = par_typ ? logic'(($countones(data) % 2) == 0) : logic'(($countones(data) % 2) == 1);
        else                        b = 1'b1;
        exp_line[cyc + 2 + i] = b;
      end
      for (int k = 1; k <= len + 1; k++) exp_busy[cyc + k] = 1'b1;
      for (int k = 2; k <= W + 1; k++)   exp_ser[cyc + k]  = 1'b1;
      phase    = 0;
      len_cur  = len;
      last_acc = cyc;
    end else if (phase >= 0) begin
      phase++;
      if (phase == len_cur) phase = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a byte with valid held until the model sees it accepted.
  task automatic send_frame(input logic [W-1:0] d, input logic pe, input logic pt, output int acc_cyc);
    int prev;
    data    = d;
    par_en  = pe;
    par_typ = pt;
    valid   = 1'b1;
    acc_cyc = -1;
    for (int budget = 0; budget < 40; budget++) begin
      prev = last_acc;
      tick();
      if (last_acc != prev) begin
        acc_cyc = last_acc;
        break;
      end
    end
    valid = 1'b0;
    if (acc_cyc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         pe;
    logic         pt;
    logic [10:0]  exp_bits;  // line bit i at position i, start bit first
    int           exp_len;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int a, a1, a2, l0, s0, gaps;
    logic [10:0] got;

    vecs[0] = '{8'h0C, 1'b0, 1'b0, 11'h218, 10};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11'h54A, 11};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 11'h74A, 11};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 11'h602, 11};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 11'h2AA, 10};

    for (int k = 0; k < N; k++) begin
      exp_line[k] = 1'b1;
      exp_busy[k] = 1'b0;
      exp_ser[k]  = 1'b0;
    end

    rst = 1'b1; data = '0; valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    run(20);

    // Directed frame table
    for (int v = 0; v < 5; v++) begin
      s0 = ser_seen;
      send_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, a);
      run(14);
      got = '0;
      for (int i = 0; i < vecs[v].exp_len; i++) got[i] = act_line[a + 2 + i];
      check("frame_bits", {21'd0, got}, {21'd0, vecs[v].exp_bits});
      check("line_after_frame", {31'd0, act_line[a + 2 + vecs[v].exp_len]}, 32'd1);
      check("ser_en_cycles", ser_seen - s0, W);
    end

    // Back-to-back: valid held across two bytes, second accept in STOP
    l0 = latche_seen;
    data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; valid = 1'b1;
    a1 = -1;
    for (int b = 0; b < 40 && a1 < 0; b++) begin
      tick();
      if (latche_seen != l0) a1 = last_latche;
    end
    data = 8'hC3;
    a2 = -1;
    for (int b = 0; b < 40 && a2 < 0; b++) begin
      tick();
      if (latche_seen == l0 + 2) a2 = last_latche;
    end
    valid = 1'b0;
    run(14);
    check("b2b_accept_spacing", a2 - a1, 10);
    check("b2b_latche_count", latche_seen - l0, 2);
    gaps = 0;
    for (int k = a1 + 1; k <= a2 + 11; k++) if (act_busy[k] !== 1'b1) gaps++;
    check("b2b_busy_gaps", gaps, 0);
    check("b2b_stop_then_start", {30'd0, act_line[a2 + 1], act_line[a2 + 2]}, 32'b10);

    // Valid raised during START/DATA/PARITY is held off until STOP
    l0 = latche_seen;
    send_frame(8'h5A, 1'b1, 1'b0, a1);
    data = 8'h99; par_en = 1'b1; par_typ = 1'b1; valid = 1'b1;
    a2 = -1;
    for (int b = 0; b < 40 && a2 < 0; b++) begin
      tick();
      if (latche_seen == l0 + 2) a2 = last_latche;
    end
    valid = 1'b0;
    run(16);
    check("held_accept_spacing", a2 - a1, 11);
    check("held_latche_count", latche_seen - l0, 2);

    // Reset pulse in the middle of DATA, then a clean 0x55 frame
    send_frame(8'hFF, 1'b0, 1'b0, a);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_tx", {31'd0, tx}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_ready", {31'd0, ready}, 32'd1);
    send_frame(vecs[4].d, vecs[4].pe, vecs[4].pt, a);
    run(14);
    got = '0;
    for (int i = 0; i < vecs[4].exp_len; i++) got[i] = act_line[a + 2 + i];
    check("post_reset_frame", {21'd0, got}, {21'd0, vecs[4].exp_bits});

    // Randomized traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      valid   = ($urandom_range(0, 2) == 0);
      data    = W'($urandom);
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    valid = 1'b0;
    run(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_fsm.md
# uart_tx_frame_fsm

Framing controller for the UART transmit path. It sits directly upstream of the `serializer`, drives that block's `i_latche_en` and `i_ser_en`, and consumes its `o_ser_data` and `o_ser_done`. It builds each frame as start bit, DATA_WIDTH data bits LSB-first, an optional parity bit and one stop bit, and drives the registered TX line. `i_clk` is the TX bit clock, so one clock equals one bit time.

## Interface
- DATA_WIDTH, default 8 (from UART_PACKAGE): data bits per frame; must match the `serializer`.
- i_clk  input  1  TX bit clock; all state changes on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled on accept.
- i_data_valid  input  1  upstream has a byte on i_P_DATA.
- o_data_ready  output  1  block can accept a byte this cycle.
- i_par_en  input  1  1 = insert a parity bit; sampled on accept.
- i_par_typ  input  1  0 = even parity, 1 = odd parity; sampled on accept.
- o_latche_en  output  1  one-cycle load strobe to the `serializer`.
- o_ser_en  output  1  shift enable to the `serializer`.
- i_ser_data  input  1  current serial bit from the `serializer`.
- i_ser_done  input  1  the `serializer` is presenting its last data bit.
- o_tx_out  output  1  UART line, registered; idles high.
- o_busy  output  1  a frame is in progress on the line.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- Accept condition: `i_data_valid && o_data_ready`.
  - `o_data_ready` = state is IDLE or STOP.
  - On accept, `o_latche_en` = 1 (combinational, same cycle) and the next state is START.
  - On accept, the block captures `par_en_q`, `par_typ_q` and the parity bit.
  - Parity bit: `^i_P_DATA` for even, `~^i_P_DATA` for odd.
- IDLE: mux bit = 1. With no accept, stay in IDLE.
- START: mux bit = 0, `o_ser_en` = 0. Next state is DATA.
- DATA: mux bit = `i_ser_data`, `o_ser_en` = 1.
  - On `i_ser_done`, go to PARITY if `par_en_q`, else STOP.
- PARITY: mux bit = parity bit. Next state is STOP.
- STOP: mux bit = 1.
  - On accept, go to START. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- `o_tx_out` is a register loaded every cycle with the mux bit. The line therefore lags the state by one cycle.
- `o_busy` = (state != IDLE) or (`o_tx_out` holds the final stop bit). It deasserts in the same cycle the line returns to idle.
- `serializer` contract:
  - On `o_latche_en`, it loads data at the next edge.
  - While `o_ser_en` is high, `i_ser_data` is the current LSB, and the register shifts at each edge.
  - `i_ser_done` is high in the cycle the DATA_WIDTH-th bit is presented.
- Data inputs are ignored while `o_data_ready` is low. A held `i_data_valid` is not lost; it is accepted in the next STOP or IDLE cycle.

## Timing
- Reset values: state IDLE, `o_tx_out` = 1, `o_busy` = 0, `o_data_ready` = 1, `o_latche_en` = 0, `o_ser_en` = 0, parity registers 0.
- Reset mid-frame: at the next edge the block enters IDLE and the line is forced high. Reset takes priority over any accept in the same cycle.
- Frame timeline, with the accept at edge E0 and DATA_WIDTH = 8:
  - START is active from E1 to E2.
  - DATA runs from E2 to E10.
  - PARITY, if enabled, runs from E10 to E11.
  - STOP runs from E11 to E12.
- The same frame on `o_tx_out`:
  - Start bit from E2 to E3.
  - Data bits from E3 to E11.
  - Parity from E11 to E12.
  - Stop bit from E12 to E13.
  - Total: 11 bit times with parity, 10 without.
- Latency from accept to the start bit appearing on the line: 2 cycles.
- With parity disabled, STOP begins one cycle earlier and every later time shifts by -1.
- Back-to-back: an accept in the STOP cycle puts the next start bit on the line immediately after the stop bit. The line shows no idle-high gap.
- If `i_ser_done` never arrives, the block stays in DATA; there is no timeout. Bench check: `i_ser_done` must occur exactly DATA_WIDTH cycles after DATA is entered.

## Test plan
- Reset, no stimulus -> `o_tx_out` = 1, `o_busy` = 0, `o_data_ready` = 1, `o_latche_en` = `o_ser_en` = 0 for 20 cycles.
- `i_P_DATA` = 0x0C, `i_par_en` = 0 -> line reads 0,0,0,1,1,0,0,0,0,1 starting 2 cycles after accept; `o_ser_en` is high for exactly 8 cycles.
- 0xA5 with even parity -> parity bit 0. 0xA5 with odd parity -> parity bit 1. 0x01 with even parity -> parity bit 1. Each frame is 11 line bits.
- `i_data_valid` held high with 0x3C then 0xC3 -> the second accept occurs in the STOP cycle, the start bit follows the stop bit directly, `o_busy` never drops between frames, and no `o_latche_en` fires during DATA.
- `i_reset` pulsed for one cycle in the middle of DATA -> next cycle state is IDLE; one cycle later `o_tx_out` = 1, `o_busy` = 0; a new 0x55 frame then transmits correctly.
- `i_data_valid` asserted during START/DATA/PARITY -> `o_data_ready` = 0 and no `o_latche_en` until STOP; the byte is then accepted exactly once.
